// File: rtl/sam_rv32i_wb_trace.sv
// Retirement trace buffer for the sam_rv32i core: captures (NPC, WB_OUT) whenever NPC
// changes and offers the entries through a show-ahead valid/ready FIFO.
module sam_rv32i_wb_trace #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          RN,
    input  logic [31:0]   NPC,
    input  logic [31:0]   WB_OUT,
    input  logic          en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_npc,
    output logic [31:0]   out_wb,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic [15:0]   ovf_cnt
);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   last_npc;
    logic          first;
    logic          cap;
    logic          pop;
    logic          push;

    assign cap       = en & (first | (NPC != last_npc));
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push      = cap & ((count < DEPTH_CNT) | pop);
    assign empty     = (count == '0);
    assign full      = (count == DEPTH_CNT);
    assign out_valid = !empty;
    assign {out_npc, out_wb} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {NPC, WB_OUT};
        end
    end

    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf_cnt  <= '0;
            last_npc <= '0;
            first    <= 1'b1;
        end else begin
            // last_npc tracks every capture, accepted or dropped, so a stalled NPC drops only once.
            if (cap) begin
                last_npc <= NPC;
                first    <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            if (cap && !push && (ovf_cnt != 16'hFFFF)) begin
                ovf_cnt <= ovf_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sam_rv32i_wb_trace.sv
// Bench for sam_rv32i_wb_trace: queue-based trace model checked every cycle, directed
// scenarios with literal expectations, then a randomized phase.
module tb_sam_rv32i_wb_trace;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk       = 1'b0;
    logic        RN        = 1'b0;
    logic [31:0] NPC       = '0;
    logic [31:0] WB_OUT    = '0;
    logic        en        = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_npc;
    logic [31:0] out_wb;
    logic [AW:0] count;
    logic        full;
    logic        empty;
    logic [15:0] ovf_cnt;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    bit checking_on = 1'b0;

    logic [63:0] mq[$];
    logic [31:0] m_last  = '0;
    bit          m_first = 1'b1;
    int          m_ovf   = 0;

    sam_rv32i_wb_trace #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .RN(RN), .NPC(NPC), .WB_OUT(WB_OUT), .en(en),
        .out_valid(out_valid), .out_ready(out_ready), .out_npc(out_npc), .out_wb(out_wb),
        .count(count), .full(full), .empty(empty), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    // Trace model: a plain queue of entries with drop counting.
    always @(posedge clk or negedge RN) begin
        bit do_pop;
        bit do_cap;
        bit accept;
        if (!RN) begin
            mq.delete();
            m_last  = '0;
            m_first = 1'b1;
            m_ovf   = 0;
        end else begin
            do_pop = (mq.size() > 0) && out_ready;
            do_cap = en && (m_first || (NPC != m_last));
            accept = do_cap && ((mq.size() < DEPTH) || do_pop);
            if (do_pop) void'(mq.pop_front());
            if (do_cap) begin
                m_last  = NPC;
                m_first = 1'b0;
                if (accept) mq.push_back({NPC, WB_OUT});
                else if (m_ovf < 65535) m_ovf++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] head;
        if (checking_on) begin
            checkOutput("model out_valid", 32'(out_valid), 32'(mq.size() != 0));
            checkOutput("model count", 32'(count), 32'(mq.size()));
            checkOutput("model full", 32'(full), 32'(mq.size() == DEPTH));
            checkOutput("model empty", 32'(empty), 32'(mq.size() == 0));
            checkOutput("model ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
            if (mq.size() != 0) begin
                head = mq[0];
                checkOutput("model out_npc", out_npc, head[63:32]);
                checkOutput("model out_wb", out_wb, head[31:0]);
            end
        end
    end

    // Inputs change shortly after the falling edge; returns just after the next rising edge.
    task automatic applyStimulus(input logic rn, input logic [31:0] npc, input logic [31:0] wb,
                                 input logic e, input logic r);
        @(negedge clk);
        #1;
        RN = rn; NPC = npc; WB_OUT = wb; en = e; out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] got[$];
        int bad;
        int rdy_pct;

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checking_on = 1'b1;
        checkOutput("reset count", 32'(count), 32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset empty", 32'(empty), 32'd1);
        checkOutput("reset full", 32'(full), 32'd0);

        applyStimulus(1'b1, 32'h0, 32'h11, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h4, 32'h22, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h8, 32'h33, 1'b1, 1'b0);
        checkOutput("step count", 32'(count), 32'd3);
        checkOutput("step head npc", out_npc, 32'h0);
        checkOutput("step head wb", out_wb, 32'h11);
        applyStimulus(1'b1, 32'h8, 32'h33, 1'b1, 1'b1);
        checkOutput("pop1 npc", out_npc, 32'h4);
        checkOutput("pop1 wb", out_wb, 32'h22);
        applyStimulus(1'b1, 32'h8, 32'h33, 1'b1, 1'b1);
        checkOutput("pop2 npc", out_npc, 32'h8);
        checkOutput("pop2 wb", out_wb, 32'h33);
        applyStimulus(1'b1, 32'h8, 32'h33, 1'b1, 1'b1);
        checkOutput("pop3 empty", 32'(empty), 32'd1);

        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'h10, 32'(i), 1'b1, 1'b0);
        checkOutput("hold count", 32'(count), 32'd1);
        checkOutput("hold head npc", out_npc, 32'h10);
        checkOutput("hold head wb", out_wb, 32'h0);
        applyStimulus(1'b1, 32'h10, 32'h0, 1'b1, 1'b1);
        checkOutput("hold drained", 32'(count), 32'd0);

        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'h100 + 32'(4 * i), 32'(i), 1'b1, 1'b0);
        checkOutput("ovf full", 32'(full), 32'd1);
        checkOutput("ovf count", 32'(count), 32'd16);
        checkOutput("ovf ovf_cnt", 32'(ovf_cnt), 32'd4);
        checkOutput("ovf head", out_npc, 32'h100);

        applyStimulus(1'b1, 32'h200, 32'hAA, 1'b1, 1'b1);
        checkOutput("fullpop count", 32'(count), 32'd16);
        checkOutput("fullpop ovf_cnt", 32'(ovf_cnt), 32'd4);
        checkOutput("fullpop head", out_npc, 32'h104);

        for (int k = 0; k < 40 && out_valid; k++) begin
            got.push_back(out_npc);
            applyStimulus(1'b1, 32'h200, 32'hAA, 1'b1, 1'b1);
        end
        checkOutput("drain entries", 32'(got.size()), 32'd16);
        bad = 0;
        foreach (got[j]) if (got[j] >= 32'h140 && got[j] <= 32'h14C) bad++;
        checkOutput("dropped absent", 32'(bad), 32'd0);
        if (got.size() >= 2) begin
            checkOutput("drain last", got[got.size() - 1], 32'h200);
            checkOutput("drain before tail", got[got.size() - 2], 32'h13C);
        end
        checkOutput("drain empty", 32'(empty), 32'd1);

        applyStimulus(1'b1, 32'h20, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h24, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h28, 32'h0, 1'b0, 1'b0);
        checkOutput("gated count", 32'(count), 32'd0);
        applyStimulus(1'b1, 32'h28, 32'h55, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h28, 32'h66, 1'b1, 1'b0);
        checkOutput("reenable count", 32'(count), 32'd1);
        checkOutput("reenable npc", out_npc, 32'h28);
        checkOutput("reenable wb", out_wb, 32'h55);
        applyStimulus(1'b1, 32'h28, 32'h55, 1'b1, 1'b1);

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h300 + 32'(4 * i), 32'(i), 1'b1, 1'b0);
        checkOutput("pre-reset count", 32'(count), 32'd5);
        checkOutput("pre-reset ovf_cnt", 32'(ovf_cnt), 32'd4);
        #2;
        RN = 1'b0;
        #1;
        checkOutput("async count", 32'(count), 32'd0);
        checkOutput("async out_valid", 32'(out_valid), 32'd0);
        checkOutput("async ovf_cnt", 32'(ovf_cnt), 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 800; i++) begin
            rdy_pct = ((i / 100) % 2 == 1) ? 80 : 15;
            applyStimulus($urandom_range(0, 149) != 0, 32'(4 * $urandom_range(0, 7)), $urandom,
                          $urandom_range(0, 9) < 8, $urandom_range(0, 99) < rdy_pct);
        end

        checking_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule
